// File: rtl/noc_rr_arbiter.sv
// Round-robin NoC output arbiter with a registered rts / dcts flit handshake.
// Define NOC_ARB_BURST_LIMIT_EN to force rotation after MAX_BURST grants to one port.
module noc_rr_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int IDLE_FIRST = 0,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               dcts,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] xbar_sel,
  output logic               rts
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || IDLE_FIRST < 0 || IDLE_FIRST >= NUM_REQ ||
      MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $error("noc_rr_arbiter: parameter out of range");
  end

  logic             sel_valid, sel_valid_nxt;
  logic [IDX_W-1:0] sel_idx, sel_idx_nxt;
  logic             rts_ff, rts_nxt;
  logic             hold, granting, limit_hit, found;
  logic [IDX_W-1:0] start_idx, found_idx;
  int               idx;

  // A pending flit (rts up, downstream not ready) freezes the selection.
  assign hold     = rts_ff && !dcts;
  assign granting = sel_valid && rts_ff && dcts;

  always_comb begin
    start_idx = IDX_W'(IDLE_FIRST);
    if (sel_valid) begin
      if (limit_hit)
        start_idx = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      else
        start_idx = sel_idx;
    end
  end

  // NOTE: blocking '=' inside always_comb is intended (idx is a scratch value
  // reused within one evaluation); registers below use '<=' only.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(start_idx) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        found_idx = IDX_W'(idx);
      end
    end
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the ifs can leave a value held and infer a latch.
  always_comb begin
    sel_valid_nxt = sel_valid;
    sel_idx_nxt   = sel_idx;
    if (!hold) begin
      sel_valid_nxt = found;
      if (found) sel_idx_nxt = found_idx;
    end
    rts_nxt = sel_valid && !(rts_ff && dcts);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_valid <= 1'b0;
      sel_idx   <= '0;
      rts_ff    <= 1'b0;
    end else begin
      sel_valid <= sel_valid_nxt;
      sel_idx   <= sel_idx_nxt;
      rts_ff    <= rts_nxt;
    end
  end

`ifdef NOC_ARB_BURST_LIMIT_EN
  logic [7:0] burst_cnt;
  logic       sel_change;

  assign limit_hit  = burst_cnt >= 8'(MAX_BURST);
  assign sel_change = (sel_valid && !sel_valid_nxt) || (sel_idx_nxt != sel_idx);

  always_ff @(posedge clk) begin
    if (rst)
      burst_cnt <= '0;
    else if (sel_change)
      burst_cnt <= '0;
    else if (granting && burst_cnt != 8'hFF)
      burst_cnt <= burst_cnt + 8'd1;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    grant    = '0;
    xbar_sel = '0;
    if (sel_valid) begin
      xbar_sel[sel_idx] = 1'b1;
      grant[sel_idx]    = granting;
    end
  end

  assign rts = rts_ff;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: directed vector tables, hand-built
// corner sequences, then random traffic against a queue-based reference model.
module tb_noc_rr_arbiter;
  localparam int N          = 5;
  localparam int IDLE_FIRST = 0;
  localparam int MAX_BURST  = 2;
`ifdef NOC_ARB_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         dcts;
    logic [N-1:0] grant;
    logic [N-1:0] xbar;
    logic         rts;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, dcts, rts;
  logic [N-1:0] req, grant, xbar_sel;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: holder index, whether a flit is offered, grants so far.
  bit m_valid = 1'b0;
  int m_idx   = 0;
  bit m_rts   = 1'b0;
  int m_cnt   = 0;

  noc_rr_arbiter #(.NUM_REQ(N), .IDLE_FIRST(IDLE_FIRST), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .dcts(dcts),
    .grant(grant), .xbar_sel(xbar_sel), .rts(rts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] q, input logic d);
    int start, pick, old_idx;
    bit was_valid, granted, next_rts;
    int order[$];
    if (r) begin
      m_valid = 1'b0; m_idx = 0; m_rts = 1'b0; m_cnt = 0;
      return;
    end
    was_valid = m_valid;
    old_idx   = m_idx;
    granted   = m_valid && m_rts && d;
    next_rts  = m_valid && !(m_rts && d);
    if (!(m_rts && !d)) begin
      if (!m_valid) start = IDLE_FIRST;
      else if (BURST_ON && m_cnt >= MAX_BURST) start = (m_idx + 1) % N;
      else start = m_idx;
      for (int k = 0; k < N; k++) order.push_back((start + k) % N);
      pick = -1;
      foreach (order[k]) if (pick < 0 && q[order[k]]) pick = order[k];
      if (pick < 0) m_valid = 1'b0;
      else begin
        m_valid = 1'b1;
        m_idx   = pick;
      end
    end
    if ((was_valid && !m_valid) || m_idx != old_idx) m_cnt = 0;
    else if (granted) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_rts = next_rts;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] q, input logic d);
    rst  = r;
    req  = q;
    dcts = d;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step(rst, req, dcts);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] g,
                            input logic [N-1:0] x, input logic r);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " xbar_sel"}, 32'(xbar_sel), 32'(x));
    check({tag, " rts"}, 32'(rts), 32'(r));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive(v.rst, v.req, v.dcts);
    expect_out(tag, v.grant, v.xbar, v.rts);
    advance();
  endtask

  task automatic do_reset();
    drive(1'b1, '0, 1'b0);
    advance();
  endtask

  task automatic step_exp(input string tag, input logic [N-1:0] q, input logic d,
                          input logic [N-1:0] g, input logic [N-1:0] x, input logic r);
    drive(1'b0, q, d);
    expect_out(tag, g, x, r);
    advance();
  endtask

  vec_t reset_tbl[9];
  vec_t burst_tbl[11];

  initial begin
    // Reset held with every port requesting, then a lone requester on port 2.
    reset_tbl[0] = '{1'b1, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0};
    reset_tbl[1] = '{1'b1, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0};
    reset_tbl[2] = '{1'b0, 5'b00100, 1'b1, 5'b00000, 5'b00000, 1'b0};
    reset_tbl[3] = '{1'b0, 5'b00100, 1'b1, 5'b00000, 5'b00100, 1'b0};
    reset_tbl[4] = '{1'b0, 5'b00100, 1'b1, 5'b00100, 5'b00100, 1'b1};
    reset_tbl[5] = '{1'b0, 5'b00100, 1'b1, 5'b00000, 5'b00100, 1'b0};
    reset_tbl[6] = '{1'b0, 5'b00100, 1'b1, 5'b00100, 5'b00100, 1'b1};
    reset_tbl[7] = '{1'b0, 5'b00100, 1'b1, 5'b00000, 5'b00100, 1'b0};
    reset_tbl[8] = '{1'b0, 5'b00100, 1'b1, 5'b00100, 5'b00100, 1'b1};

    // Ports 0 and 1 both requesting with dcts high; first row follows a reset.
    burst_tbl[0] = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00000, 1'b0};
    burst_tbl[1] = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00001, 1'b0};
    burst_tbl[2] = '{1'b0, 5'b00011, 1'b1, 5'b00001, 5'b00001, 1'b1};
    burst_tbl[3] = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00001, 1'b0};
    burst_tbl[4] = '{1'b0, 5'b00011, 1'b1, 5'b00001, 5'b00001, 1'b1};
    burst_tbl[5] = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00001, 1'b0};
`ifdef NOC_ARB_BURST_LIMIT_EN
    burst_tbl[6]  = '{1'b0, 5'b00011, 1'b1, 5'b00010, 5'b00010, 1'b1};
    burst_tbl[7]  = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00010, 1'b0};
    burst_tbl[8]  = '{1'b0, 5'b00011, 1'b1, 5'b00010, 5'b00010, 1'b1};
    burst_tbl[9]  = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00010, 1'b0};
    burst_tbl[10] = '{1'b0, 5'b00011, 1'b1, 5'b00001, 5'b00001, 1'b1};
`else
    burst_tbl[6]  = '{1'b0, 5'b00011, 1'b1, 5'b00001, 5'b00001, 1'b1};
    burst_tbl[7]  = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00001, 1'b0};
    burst_tbl[8]  = '{1'b0, 5'b00011, 1'b1, 5'b00001, 5'b00001, 1'b1};
    burst_tbl[9]  = '{1'b0, 5'b00011, 1'b1, 5'b00000, 5'b00001, 1'b0};
    burst_tbl[10] = '{1'b0, 5'b00011, 1'b1, 5'b00001, 5'b00001, 1'b1};
`endif

    drive(1'b1, '1, 1'b1);
    advance();
    foreach (reset_tbl[i]) run_vec($sformatf("reset_single[%0d]", i), reset_tbl[i]);

    do_reset();
    foreach (burst_tbl[i]) run_vec($sformatf("burst[%0d]", i), burst_tbl[i]);

    // Backpressure on holder 3; holder later drops req while the flit is pending.
    do_reset();
    step_exp("bp sel",  5'b01000, 1'b0, 5'b00000, 5'b00000, 1'b0);
    step_exp("bp hold", 5'b01001, 1'b0, 5'b00000, 5'b01000, 1'b0);
    for (int i = 0; i < 3; i++)
      step_exp($sformatf("bp stall%0d", i), 5'b01001, 1'b0, 5'b00000, 5'b01000, 1'b1);
    for (int i = 0; i < 2; i++)
      step_exp($sformatf("bp drop%0d", i), 5'b00001, 1'b0, 5'b00000, 5'b01000, 1'b1);
    step_exp("bp grant", 5'b00001, 1'b1, 5'b01000, 5'b01000, 1'b1);
    step_exp("bp wrap",  5'b00001, 1'b1, 5'b00000, 5'b00001, 1'b0);

    // Rotation: holder 4 drops -> wraps to 0; holder 0 drops -> 1.
    do_reset();
    step_exp("rot sel4",  5'b10000, 1'b1, 5'b00000, 5'b00000, 1'b0);
    step_exp("rot hold4", 5'b10000, 1'b1, 5'b00000, 5'b10000, 1'b0);
    step_exp("rot gnt4",  5'b00011, 1'b1, 5'b10000, 5'b10000, 1'b1);
    step_exp("rot sel0",  5'b00010, 1'b1, 5'b00000, 5'b00001, 1'b0);
    step_exp("rot gnt1",  5'b00010, 1'b1, 5'b00010, 5'b00010, 1'b1);

    // Reset while a flit is pending must abort it, regardless of dcts.
    do_reset();
    step_exp("mrst sel",   5'b00100, 1'b0, 5'b00000, 5'b00000, 1'b0);
    step_exp("mrst up",    5'b00100, 1'b0, 5'b00000, 5'b00100, 1'b0);
    step_exp("mrst stall", 5'b00100, 1'b0, 5'b00000, 5'b00100, 1'b1);
    drive(1'b1, 5'b00100, 1'b0);
    expect_out("mrst in_rst", 5'b00000, 5'b00100, 1'b1);
    advance();
    step_exp("mrst after", 5'b00100, 1'b1, 5'b00000, 5'b00000, 1'b0);
    step_exp("mrst resel", 5'b00100, 1'b1, 5'b00000, 5'b00100, 1'b0);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic         r, d;
      logic [N-1:0] q;
      r = ($urandom_range(0, 79) == 0);
      q = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) q = onehot($urandom_range(0, N - 1));
      if ($urandom_range(0, 9) == 0) q = '0;
      d = ($urandom_range(0, 2) != 0);
      drive(r, q, d);
      expect_out($sformatf("rand[%0d]", c),
                 (m_valid && m_rts && d) ? onehot(m_idx) : '0,
                 m_valid ? onehot(m_idx) : '0,
                 m_rts);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5: number of requesting input ports, legal range 2..16.
REQ-002 Parameter IDLE_FIRST, default 0: index searched first when leaving IDLE, legal range 0..NUM_REQ-1.
REQ-003 Parameter MAX_BURST, default 4: consecutive grants allowed to one port before forced rotation, legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  NUM_REQ  per-port request, level-sensitive.
REQ-007 dcts  input  1  downstream clear-to-send.
REQ-008 grant  output  NUM_REQ  one-hot-or-zero grant, combinational from registered state and dcts.
REQ-009 xbar_sel  output  NUM_REQ  one-hot crossbar select of the held port; all-zero in IDLE.
REQ-010 rts  output  1  registered request-to-send toward downstream.

Function
REQ-011 Registered state: sel_valid (0 = IDLE, 1 = HOLD), sel_idx [clog2(NUM_REQ)-1:0], rts_ff, burst_cnt [7:0].
REQ-012 rts SHALL equal rts_ff with no combinational path.
REQ-013 rts_ff next value: 0 in IDLE; 0 in HOLD when rts_ff && dcts; 1 otherwise.
REQ-014 grant[sel_idx] SHALL equal dcts && rts_ff in HOLD; all other grant bits 0; all bits 0 in IDLE.
REQ-015 xbar_sel[sel_idx] = 1 in HOLD regardless of rts/dcts; all bits 0 in IDLE.
REQ-016 Selection hold: when rts_ff && !dcts, sel_valid and sel_idx SHALL NOT change.
REQ-017 Otherwise next selection = first asserted req bit in circular order from a start index, wrapping NUM_REQ-1 -> 0; no request asserted -> IDLE.
REQ-018 Start index: IDLE_FIRST in IDLE; sel_idx in HOLD (current holder keeps priority); sel_idx+1 mod NUM_REQ when burst limit reached (REQ-021).
REQ-019 Grant-to-rts latency: port selected at edge t -> rts=1 after edge t+1 -> grant in the first cycle with dcts=1 -> rts=0 the following cycle (one-cycle rts gap between flits).
REQ-020 Simultaneous requests are resolved only by REQ-017/018; no two grant bits are ever high together.
REQ-021 Burst counting: burst_cnt increments (saturating at 255) on each cycle with a grant bit high; it clears to 0 when sel_idx changes or on entering IDLE; limit reached when burst_cnt >= MAX_BURST.
REQ-022 Holder dropping req while rts_ff=1 and dcts=0 SHALL NOT change selection (REQ-016 wins); grant still pulses when dcts rises.
REQ-023 A req bit at an index >= NUM_REQ does not exist; sel_idx SHALL never exceed NUM_REQ-1.

Reset
REQ-024 With rst=1 at a clock edge: sel_valid=0, sel_idx=0, rts_ff=0, burst_cnt=0; hence rts=0, grant=0, xbar_sel=0 from the next cycle.
REQ-025 rst asserted mid-handshake (rts=1) SHALL abort it; no grant is issued in the cycle following reset, whatever dcts is.
REQ-026 First selection after reset deasserts follows REQ-017 from IDLE.

Configuration
REQ-027 Macro NOC_ARB_BURST_LIMIT_EN: when defined, REQ-021 and the burst-limit case of REQ-018 are compiled in.
REQ-028 Without NOC_ARB_BURST_LIMIT_EN: burst_cnt is absent, MAX_BURST is ignored, and the holder keeps the port for as long as it requests (pure hold-then-rotate).

Verification (NUM_REQ=5, IDLE_FIRST=0, MAX_BURST=2, macro defined unless stated)
REQ-029 Reset: rst=1 two cycles with req=5'b11111, dcts=1 -> rts=0, grant=0, xbar_sel=0 throughout and one cycle after release.
REQ-030 Single port: req=5'b00100, dcts=1 -> xbar_sel=5'b00100 at edge 1, rts=1 at edge 2, grant=5'b00100 in that cycle, rts=0 next, repeating every 2 cycles.
REQ-031 Backpressure: port 3 holds, rts=1, dcts=0 for 5 cycles while req=5'b01001 -> rts stays 1, grant=0, xbar_sel=5'b01000; dcts=1 -> single grant=5'b01000.
REQ-032 Rotation with wrap: holder 4 drops req, req=5'b00011 -> next selection index 0; then holder 0 drops -> index 1.
REQ-033 Burst limit: req=5'b00011, dcts=1 -> port 0 granted 2 times, then port 1 granted 2 times, then port 0 again; with macro undefined port 0 granted indefinitely.
REQ-034 Mid-handshake reset: rts=1, dcts=0, rst=1 for one cycle, dcts=1 -> rts=0 and grant=0 in the cycle after reset.
